mem_access_unit: RTL and testbench

//  MEM-stage data-memory access unit of the 5-stage RV32I pipeline. Sits between EX/MEM and MEM/WB.

---
 rtl/mem_access_unit_pkg.sv | 45 ++++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_load_extend.sv | 29 ++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage access unit: RV32I load/store funct3 encodings,
// the access FSM state type and the fault-check helper.
package mem_access_unit_pkg;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mau_state_t;

  // True when the access is misaligned for its width or funct3 is undefined
  // for its direction (loads and stores have different legal sets).
  function automatic logic access_fault_chk(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      3'b000: ok = 1'b1;
      3'b001: ok = ~addr_lo[0];
      3'b010: ok = (addr_lo == 2'b00);
      3'b100: ok = ~is_store;
      3'b101: ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ~ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus. The access unit is the master, the memory the slave.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  dmem_read;
  logic                  dmem_write;
  logic [ADDR_W-1:0]     dmem_address;
  logic [DATA_W/8-1:0]   dmem_byte_enable;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_resp;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load data alignment: picks the byte/half addressed by addr[1:0] out of the
// returned word and sign- or zero-extends it according to funct3.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select then extension; halves only ever sit at offset 0 or 2.
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    o_data = i_rdata;
    case (load_funct3_t'(i_funct3))
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: runs the dmem handshake, forms store lanes
// and byte enables, extends load data and stalls the pipe while busy.
// Optional build macro MAU_PERF_CNT_EN adds stall-cycle and access counters.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic [2:0]        i_ex_funct3,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_rs2,
  input  logic              i_pipe_hold,
  mem_access_unit_if.master dmem,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_mem_busy,
`ifdef MAU_PERF_CNT_EN
  output logic [31:0]       o_dmem_stall_cycles,
  output logic [31:0]       o_dmem_access_count,
`endif
  output logic              o_access_fault
);

  mau_state_t        r_state;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_read_data;
  logic              r_fault;

  logic              w_access;
  logic              w_is_store;
  logic              w_fault;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  // A set write flag wins: read+write is handled as a store.
  assign w_access   = i_ex_valid & (i_ex_mem_read | i_ex_mem_write);
  assign w_is_store = i_ex_mem_write;
  assign w_fault    = w_access & access_fault_chk(w_is_store, i_ex_funct3, i_ex_addr[1:0]);

  // Store lane replication and byte enables; loads always read the full word.
  always_comb begin
    w_be    = BE_ALL;
    w_wdata = i_ex_rs2;
    if (w_is_store) begin
      case (store_funct3_t'(i_ex_funct3))
        ST_SB: begin
          w_be    = 4'b0001 << i_ex_addr[1:0];
          w_wdata = {4{i_ex_rs2[7:0]}};
        end
        ST_SH: begin
          w_be    = 4'b0011 << i_ex_addr[1:0];
          w_wdata = {2{i_ex_rs2[15:0]}};
        end
        default: begin
          w_be    = BE_ALL;
          w_wdata = i_ex_rs2;
        end
      endcase
    end
  end

  mem_access_unit_load_extend u_load_extend (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (dmem.dmem_rdata),
    .o_data    (w_load_data)
  );

  // Access FSM with registered request, lane and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_funct3    <= '0;
      r_read_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_fault) begin
              r_fault     <= 1'b1;
              r_read_data <= '0;
            end else begin
              r_addr   <= i_ex_addr;
              r_be     <= w_be;
              r_wdata  <= w_wdata;
              r_funct3 <= i_ex_funct3;
              r_rd     <= ~w_is_store;
              r_wr     <= w_is_store;
              r_state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem.dmem_resp) begin
            if (r_rd) r_read_data <= w_load_data;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!i_pipe_hold) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the access is presented, hence combinational.
  assign o_mem_busy = (r_state == BUSY) | ((r_state == IDLE) & w_access & ~w_fault);

  assign dmem.dmem_read        = r_rd;
  assign dmem.dmem_write       = r_wr;
  assign dmem.dmem_address     = {r_addr[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_byte_enable = r_be;
  assign dmem.dmem_wdata       = r_wdata;
  assign o_read_data           = r_read_data;
  assign o_access_fault        = r_fault;

`ifdef MAU_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_access_count;

  // Free-running performance counters; wrap naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_access_count <= '0;
    end else begin
      if (o_mem_busy) r_stall_cycles <= r_stall_cycles + 32'd1;
      if ((r_state == BUSY) && dmem.dmem_resp) r_access_count <= r_access_count + 32'd1;
    end
  end

  assign o_dmem_stall_cycles = r_stall_cycles;
  assign o_dmem_access_count = r_access_count;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, pipe_hold;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_rs2;
  logic [31:0] read_data;
  logic        mem_busy, access_fault;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_rd  = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ex_valid     (ex_valid),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_mem_write (ex_mem_write),
    .i_ex_funct3    (ex_funct3),
    .i_ex_addr      (ex_addr),
    .i_ex_rs2       (ex_rs2),
    .i_pipe_hold    (pipe_hold),
    .dmem           (bus.master),
    .o_read_data    (read_data),
    .o_mem_busy     (mem_busy),
`ifdef MAU_PERF_CNT_EN
    .o_dmem_stall_cycles (),
    .o_dmem_access_count (),
`endif
    .o_access_fault (access_fault)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_fault(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int size;
    bit legal;
    if (wr) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (!legal) return 1'b1;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * (addr % 4));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    if (!wr) return 4'hF;
    case (f3)
      3'd0:    return 4'(1 << (addr % 4));
      3'd1:    return 4'(3 << (addr % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      3'd0:    return (rs2 % 256) * 32'h0101_0101;
      3'd1:    return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // One complete access starting and ending in IDLE (called at a negedge).
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int delay, input int hold,
                           input bit flush);
    bit          flt;
    logic [31:0] exp_addr;
    flt      = ref_fault(wr, f3, addr);
    exp_addr = addr - (addr % 4);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = addr; ex_rs2 = rs2;
    #1;
    vectors++;
    if (mem_busy !== !flt) begin
      errors++; $display("FAIL busy_present: got %b want %b (f3=%0d addr=%h)", mem_busy, !flt, f3, addr);
    end
    tick;
    if (flt) begin
      exp_rd = 32'd0;
      vectors++;
      if (access_fault !== 1'b1 || bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0 ||
          mem_busy !== 1'b0 || read_data !== exp_rd) begin
        errors++;
        $display("FAIL fault_cycle: fault=%b rd=%b wr=%b busy=%b rdata=%h want 1 0 0 0 %h",
                 access_fault, bus.dmem_read, bus.dmem_write, mem_busy, read_data, exp_rd);
      end
      ex_valid = 1'b0;
      tick;
      vectors++;
      if (access_fault !== 1'b0 || mem_busy !== 1'b0 || bus.dmem_read !== 1'b0) begin
        errors++; $display("FAIL fault_pulse_end: fault=%b busy=%b rd=%b want 0 0 0",
                           access_fault, mem_busy, bus.dmem_read);
      end
      return;
    end
    vectors++;
    if (bus.dmem_read !== !wr || bus.dmem_write !== wr || bus.dmem_address !== exp_addr ||
        bus.dmem_byte_enable !== ref_be(wr, f3, addr) || mem_busy !== 1'b1 || access_fault !== 1'b0) begin
      errors++;
      $display("FAIL request: rd=%b wr=%b addr=%h be=%b busy=%b flt=%b want %b %b %h %b 1 0",
               bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_byte_enable, mem_busy,
               access_fault, !wr, wr, exp_addr, ref_be(wr, f3, addr));
    end
    if (wr) begin
      vectors++;
      if (bus.dmem_wdata !== ref_wdata(f3, rs2)) begin
        errors++; $display("FAIL store_wdata: got %h want %h", bus.dmem_wdata, ref_wdata(f3, rs2));
      end
    end
    if (flush) ex_valid = 1'b0;
    repeat (delay) begin
      bus.dmem_rdata = $urandom;
      tick;
      vectors++;
      if (bus.dmem_read !== !wr || bus.dmem_write !== wr || mem_busy !== 1'b1) begin
        errors++; $display("FAIL request_held: rd=%b wr=%b busy=%b want %b %b 1",
                           bus.dmem_read, bus.dmem_write, mem_busy, !wr, wr);
      end
    end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = rdata;
    tick;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = $urandom;
    if (!wr) exp_rd = ref_load(f3, addr, rdata);
    vectors++;
    if (bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0 || mem_busy !== 1'b0 || read_data !== exp_rd) begin
      errors++; $display("FAIL complete: rd=%b wr=%b busy=%b data=%h want 0 0 0 %h",
                         bus.dmem_read, bus.dmem_write, mem_busy, read_data, exp_rd);
    end
    pipe_hold = 1'b1;
    repeat (hold) begin
      tick;
      vectors++;
      if (bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0 || mem_busy !== 1'b0 || read_data !== exp_rd) begin
        errors++; $display("FAIL hold_done: rd=%b wr=%b busy=%b data=%h want 0 0 0 %h",
                           bus.dmem_read, bus.dmem_write, mem_busy, read_data, exp_rd);
      end
    end
    pipe_hold = 1'b0;
    ex_valid  = 1'b0;
    tick;
    vectors++;
    if (mem_busy !== 1'b0 || bus.dmem_read !== 1'b0 || read_data !== exp_rd) begin
      errors++; $display("FAIL back_idle: busy=%b rd=%b data=%h want 0 0 %h",
                         mem_busy, bus.dmem_read, read_data, exp_rd);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    exp_rd = 32'd0;
    vectors++;
    if (bus.dmem_read !== 1'b0 || bus.dmem_write !== 1'b0 || bus.dmem_address !== 32'd0 ||
        bus.dmem_byte_enable !== 4'd0 || bus.dmem_wdata !== 32'd0 || read_data !== 32'd0 ||
        mem_busy !== 1'b0 || access_fault !== 1'b0) begin
      errors++; $display("FAIL reset_state: rd=%b wr=%b addr=%h be=%b wd=%h data=%h busy=%b flt=%b want all 0",
                         bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_byte_enable,
                         bus.dmem_wdata, read_data, mem_busy, access_fault);
    end
  endtask

  task automatic test_loads;
    do_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
    do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0);
    do_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 2, 0, 0);
    do_access(1, 0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0, 0, 0);
    do_access(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_0000, 0, 0, 1);
  endtask

  task automatic test_stores;
    do_access(0, 1, 3'd0, 32'h201, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0, 0);
    do_access(0, 1, 3'd1, 32'h202, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0);
    do_access(0, 1, 3'd2, 32'h204, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 0, 0);
    do_access(1, 1, 3'd0, 32'h207, 32'h0000_00A5, 32'h1111_1111, 0, 0, 0);
  endtask

  task automatic test_faults;
    do_access(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0, 0);
    do_access(1, 0, 3'd5, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    do_access(0, 1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    do_access(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    do_access(0, 1, 3'd2, 32'h203, 32'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_pipe_hold;
    do_access(1, 0, 3'd2, 32'h300, 32'h0, 32'h1357_9BDF, 1, 4, 0);
    do_access(0, 1, 3'd1, 32'h300, 32'hABCD_0123, 32'h0, 0, 2, 0);
  endtask

  task automatic test_rst_busy;
    do_access(1, 0, 3'd2, 32'h400, 32'h0, 32'h2468_ACE0, 0, 0, 0);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'd2; ex_addr = 32'h404;
    tick;
    ex_valid = 1'b0;
    vectors++;
    if (bus.dmem_read !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: rd=%b want 1", bus.dmem_read);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_rd = 32'd0;
    vectors++;
    if (bus.dmem_read !== 1'b0 || mem_busy !== 1'b0 || read_data !== 32'd0) begin
      errors++; $display("FAIL rst_in_busy: rd=%b busy=%b data=%h want 0 0 0",
                         bus.dmem_read, mem_busy, read_data);
    end
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hAAAA_5555;
    tick;
    bus.dmem_resp = 1'b0;
    tick;
    vectors++;
    if (read_data !== 32'd0 || bus.dmem_read !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL late_resp: data=%h rd=%b busy=%b want 0 0 0",
                         read_data, bus.dmem_read, mem_busy);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      do_access(1, 0, 3'd2, 32'h500 + 32'(4 * i), 32'h0, $urandom, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(1, 3));
      do_access(sel[0], sel[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_rs2 = 32'd0; pipe_hold = 1'b0;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = 32'd0;
    @(negedge clk);
    test_reset;
    test_loads;
    test_stores;
    test_faults;
    test_pipe_hold;
    test_rst_busy;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
